// File: rtl/sb_pkg.sv
// sb_pkg: shared sizes, counter type and register-index helpers for the write scoreboard.
package sb_pkg;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W = 2;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  localparam cnt_t CNT_MAX = '1;
  function automatic logic is_x0(input reg_idx_t r);
    return r == '0;
  endfunction
endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating up/down counter; one increment and up to two decrements net in the same cycle, floored at zero.
module sb_counter
  import sb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc_i,
  input  logic [1:0] dec_i,
  output cnt_t       cnt_o
);
  cnt_t cnt_q, cnt_d;
  logic [CNT_W+1:0] sum, net;
  always_comb begin
    sum = {2'b00, cnt_q} + {{(CNT_W+1){1'b0}}, inc_i};
    net = sum - {{CNT_W{1'b0}}, dec_i};
    cnt_d = (sum < {{CNT_W{1'b0}}, dec_i}) ? '0 : (net > {2'b00, CNT_MAX}) ? CNT_MAX : net[CNT_W-1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/reg_write_scoreboard.sv
// reg_write_scoreboard: tracks in-flight register writes and loads, stalls issue on load-use hazards and counter saturation.
// Define SB_FULL_INTERLOCK_EN to stall on any pending write to a used operand (forwarding-free core).
module reg_write_scoreboard
  import sb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                issue_wr,
  input  logic                issue_is_load,
  input  logic                kill_valid,
  input  logic [REG_IDX_W-1:0] kill_rd,
  input  logic                kill_is_load,
  input  logic                mem_done,
  input  logic [REG_IDX_W-1:0] mem_done_rd,
  input  logic                wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  output logic                issue_stall,
  output logic [NUM_REGS-1:0] pending_mask
);
  cnt_t pend_q [NUM_REGS];
  cnt_t load_q [NUM_REGS];
  logic issue_eff, load_haz, sat_haz, full_haz;
  assign issue_eff = issue_valid & issue_wr & ~issue_stall & ~is_x0(issue_rd);
  genvar r;
  generate
    for (r = 0; r < NUM_REGS; r++) begin : g_reg
      if (r == 0) begin : g_x0
        assign pend_q[r] = '0;
        assign load_q[r] = '0;
      end else begin : g_trk
        logic iss_hit, wb_hit, kill_hit, md_hit;
        assign iss_hit  = issue_eff & (issue_rd == REG_IDX_W'(r));
        assign wb_hit   = wb_valid & (wb_rd == REG_IDX_W'(r));
        assign kill_hit = kill_valid & (kill_rd == REG_IDX_W'(r));
        assign md_hit   = mem_done & (mem_done_rd == REG_IDX_W'(r));
        sb_counter u_pend (
          .clk   (clk),
          .reset (reset),
          .inc_i (iss_hit),
          .dec_i ({1'b0, wb_hit} + {1'b0, kill_hit}),
          .cnt_o (pend_q[r])
        );
        sb_counter u_load (
          .clk   (clk),
          .reset (reset),
          .inc_i (iss_hit & issue_is_load),
          .dec_i ({1'b0, md_hit} + {1'b0, kill_hit & kill_is_load}),
          .cnt_o (load_q[r])
        );
      end
      assign pending_mask[r] = pend_q[r] != '0;
    end
  endgenerate
  function automatic logic load_busy(input logic use_i, input reg_idx_t rs);
    return use_i & ~is_x0(rs) & (load_q[rs] != '0);
  endfunction
`ifdef SB_FULL_INTERLOCK_EN
  // A write landing this cycle is visible to ID through the register file.
  function automatic logic pend_busy(input logic use_i, input reg_idx_t rs);
    return use_i & ~is_x0(rs) & (pend_q[rs] != '0) & ~(wb_valid & (wb_rd == rs) & (pend_q[rs] == cnt_t'(1)));
  endfunction
  assign full_haz = pend_busy(id_use_rs1, id_rs1) | pend_busy(id_use_rs2, id_rs2);
`else
  assign full_haz = 1'b0;
`endif
  always_comb begin
    load_haz = load_busy(id_use_rs1, id_rs1) | load_busy(id_use_rs2, id_rs2);
    sat_haz = issue_valid & issue_wr & ~is_x0(issue_rd) & (pend_q[issue_rd] == CNT_MAX)
            & ~(wb_valid & (wb_rd == issue_rd)) & ~(kill_valid & (kill_rd == issue_rd));
    issue_stall = load_haz | sat_haz | full_haz;
  end
endmodule

// File: tb/tb_reg_write_scoreboard.sv
// tb_reg_write_scoreboard: directed and random stimulus against a per-register counting model.
module tb_reg_write_scoreboard;
  localparam int MAXC = 3;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, issue_rd, kill_rd, mem_done_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, issue_valid, issue_wr, issue_is_load;
  logic kill_valid, kill_is_load, mem_done, wb_valid;
  logic issue_stall;
  logic [31:0] pending_mask;
  int checks = 0, failures = 0;
  int pend[32], ld[32];

  reg_write_scoreboard dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_is_load(issue_is_load),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .kill_is_load(kill_is_load),
    .mem_done(mem_done), .mem_done_rd(mem_done_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .issue_stall(issue_stall), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {id_rs1, id_rs2, issue_rd, kill_rd, mem_done_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, issue_valid, issue_wr, issue_is_load} = '0;
    {kill_valid, kill_is_load, mem_done, wb_valid} = '0;
  endtask

  function automatic logic operand_blocked(input logic use_op, input logic [4:0] rs);
    logic b;
    b = 1'b0;
    if (use_op && rs != 0) begin
      if (ld[rs] > 0) b = 1'b1;
`ifdef SB_FULL_INTERLOCK_EN
      if (pend[rs] > 0 && !(wb_valid && wb_rd == rs && pend[rs] == 1)) b = 1'b1;
`endif
    end
    return b;
  endfunction

  function automatic logic model_stall();
    logic s;
    s = operand_blocked(id_use_rs1, id_rs1) | operand_blocked(id_use_rs2, id_rs2);
    if (issue_valid && issue_wr && issue_rd != 0 && pend[issue_rd] == MAXC &&
        !(wb_valid && wb_rd == issue_rd) && !(kill_valid && kill_rd == issue_rd)) s = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = pend[r] > 0;
    return m;
  endfunction

  function automatic int clampc(input int v);
    return v < 0 ? 0 : (v > MAXC ? MAXC : v);
  endfunction

  // Check outputs for the inputs currently driven, advance the model, cross the edge, return to idle.
  task automatic step(input string tag);
    logic s;
    int dp[32], dl[32];
    #1;
    s = model_stall();
    chk({tag, ".stall"}, {31'b0, issue_stall}, {31'b0, s});
    chk({tag, ".mask"}, pending_mask, model_mask());
    for (int r = 0; r < 32; r++) begin dp[r] = 0; dl[r] = 0; end
    if (issue_valid && issue_wr && !s) begin dp[issue_rd]++; if (issue_is_load) dl[issue_rd]++; end
    if (wb_valid) dp[wb_rd]--;
    if (kill_valid) begin dp[kill_rd]--; if (kill_is_load) dl[kill_rd]--; end
    if (mem_done) dl[mem_done_rd]--;
    for (int r = 1; r < 32; r++) begin
      pend[r] = clampc(pend[r] + dp[r]);
      ld[r] = clampc(ld[r] + dl[r]);
    end
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic issue(input logic [4:0] rd, input logic is_ld);
    issue_valid = 1; issue_wr = 1; issue_rd = rd; issue_is_load = is_ld;
  endtask

  function automatic int pick(input logic loads);
    int st;
    st = $urandom_range(1, 7);
    for (int k = 0; k < 7; k++) begin
      int r;
      r = ((st - 1 + k) % 7) + 1;
      if ((loads ? ld[r] : pend[r]) > 0) return r;
    end
    return 0;
  endfunction

  initial begin
    for (int r = 0; r < 32; r++) begin pend[r] = 0; ld[r] = 0; end
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst.stall", {31'b0, issue_stall}, 32'd0);
    chk("rst.mask", pending_mask, 32'd0);
    reset = 0;
    @(negedge clk);

    // Load-use: exactly one bubble, mem_done in the stall cycle does not release it.
    issue(5'd5, 1); step("lw5");
    id_use_rs1 = 1; id_rs1 = 5; issue(5'd10, 0); mem_done = 1; mem_done_rd = 5;
    #1 chk("lu.stall1", {31'b0, issue_stall}, 32'd1);
    step("lu.c1");
    id_use_rs1 = 1; id_rs1 = 5; issue(5'd10, 0);
    #1 chk("lu.stall0", {31'b0, issue_stall}, 32'd0);
    step("lu.c2");
    wb_valid = 1; wb_rd = 5; step("wb5");
    wb_valid = 1; wb_rd = 10; step("wb10");

    // ALU producer with forwarding.
    issue(5'd6, 0); step("add6");
    id_use_rs2 = 1; id_rs2 = 6; issue(5'd11, 0);
`ifndef SB_FULL_INTERLOCK_EN
    #1 chk("alu.nostall", {31'b0, issue_stall}, 32'd0);
`endif
    chk("alu.mask6", {31'b0, pending_mask[6]}, 32'd1);
    step("alu.use");
    wb_valid = 1; wb_rd = 6; step("wb6");
    chk("alu.mask6clr", {31'b0, pending_mask[6]}, 32'd0);
    wb_valid = 1; wb_rd = 11; step("wb11");

    // Saturation at three in flight; a same-cycle writeback frees a slot.
    repeat (3) begin issue(5'd7, 0); step("x7"); end
    issue(5'd7, 0);
    #1 chk("sat.stall", {31'b0, issue_stall}, 32'd1);
    step("sat.c");
    issue(5'd7, 0); wb_valid = 1; wb_rd = 7;
    #1 chk("sat.wbfree", {31'b0, issue_stall}, 32'd0);
    step("sat.wb");
    issue(5'd7, 0);
    #1 chk("sat.still3", {31'b0, issue_stall}, 32'd1);
    step("sat.again");
    repeat (3) begin wb_valid = 1; wb_rd = 7; step("wb7"); end
    chk("sat.drained", pending_mask, 32'd0);

    // Killed load leaves nothing behind.
    issue(5'd8, 1); step("lw8");
    kill_valid = 1; kill_rd = 8; kill_is_load = 1; step("kill8");
    id_use_rs1 = 1; id_rs1 = 8;
    #1 chk("kill.nostall", {31'b0, issue_stall}, 32'd0);
    step("kill.use");

`ifdef SB_FULL_INTERLOCK_EN
    issue(5'd9, 0); step("fi.add9");
    id_use_rs1 = 1; id_rs1 = 9; id_use_rs2 = 1; id_rs2 = 0;
    #1 chk("fi.stall", {31'b0, issue_stall}, 32'd1);
    step("fi.c1");
    id_use_rs1 = 1; id_rs1 = 9; wb_valid = 1; wb_rd = 9;
    #1 chk("fi.wt", {31'b0, issue_stall}, 32'd0);
    step("fi.c2");
`endif

    // Random traffic on a small register window so saturation and collisions happen.
    for (int n = 0; n < 400; n++) begin
      int w;
      id_use_rs1 = 1'($urandom_range(0, 1)); id_rs1 = 5'($urandom_range(0, 7));
      id_use_rs2 = 1'($urandom_range(0, 1)); id_rs2 = 5'($urandom_range(0, 7));
      issue_valid = 1'($urandom_range(0, 1)); issue_wr = 1'($urandom_range(0, 3) != 0);
      issue_rd = 5'($urandom_range(0, 7)); issue_is_load = 1'($urandom_range(0, 2) == 0);
      w = pick(0);
      if (w != 0 && $urandom_range(0, 2) != 0) begin wb_valid = 1; wb_rd = 5'(w); end
      w = pick(1);
      if (w != 0 && $urandom_range(0, 1) != 0) begin mem_done = 1; mem_done_rd = 5'(w); end
      w = pick(0);
      if (w != 0 && $urandom_range(0, 9) == 0) begin
        kill_valid = 1; kill_rd = 5'(w); kill_is_load = ld[w] > 0;
      end
      step("rnd");
    end

    // Asynchronous reset mid-stream wipes everything at once.
    issue(5'd5, 0); step("pre5a");
    issue(5'd5, 0); step("pre5b");
    chk("pre.mask5", {31'b0, pending_mask[5]}, 32'd1);
    reset = 1;
    #1 chk("arst.mask", pending_mask, 32'd0);
    chk("arst.stall", {31'b0, issue_stall}, 32'd0);
    for (int r = 0; r < 32; r++) begin pend[r] = 0; ld[r] = 0; end
    @(negedge clk);
    reset = 0;
    id_use_rs1 = 1; id_rs1 = 5; issue(5'd5, 0);
    step("post.rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
